// File: rtl/countdown_timer_16_pkg.sv
// countdown_timer_16_pkg: shared state encodings and default width for the countdown timer
package countdown_timer_16_pkg;
  localparam int BIT_SZ_DEF = 16;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2,
    ST_DONE = 2'd3
  } state_t;
endpackage

// File: rtl/countdown_timer_16_core.sv
// countdown_timer_16_core: count register with load, non-wrapping decrement and terminal detect
module countdown_timer_16_core
  import countdown_timer_16_pkg::*;
#(
  parameter int BIT_SZ = BIT_SZ_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ld,
  input  logic [BIT_SZ-1:0] ld_value,
  input  logic              dec,
  output logic [BIT_SZ-1:0] count,
  output logic              term
);
  localparam logic [BIT_SZ-1:0] ONE = {{(BIT_SZ-1){1'b0}}, 1'b1};
  assign term = dec && (count == ONE);
  // load wins over decrement; a zero count never decrements
  always_ff @(posedge clock or posedge reset)
    if (reset) count <= '0;
    else if (ld) count <= ld_value;
    else if (dec && count != '0) count <= count - ONE;
endmodule

// File: rtl/countdown_timer_16.sv
// countdown_timer_16: loadable down-counter with pause/resume and done pulse; COUNTDOWN_AUTO_RELOAD_EN adds auto-reload
module countdown_timer_16
  import countdown_timer_16_pkg::*;
#(
  parameter int BIT_SZ = BIT_SZ_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic [BIT_SZ-1:0] load_value,
  input  logic              start,
  input  logic              pause,
  input  logic              enable,
  output logic [BIT_SZ-1:0] count,
  output logic              busy,
  output logic              done,
  output logic              zero
);
  state_t state, state_nxt;
  logic dec, term, rl, ld, done_nxt;
  logic [BIT_SZ-1:0] ld_val;
  assign dec = (state == ST_RUN) && !load && !pause && enable;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
  logic [BIT_SZ-1:0] reload;
  // reload value tracks the last explicit load
  always_ff @(posedge clock or posedge reset)
    if (reset) reload <= '0;
    else if (load) reload <= load_value;
  assign rl = term && (reload != '0);
  assign ld_val = load ? load_value : reload;
`else
  assign rl = 1'b0;
  assign ld_val = load_value;
`endif
  assign ld = load || rl;
  countdown_timer_16_core #(.BIT_SZ(BIT_SZ)) u_core (
    .clock(clock),
    .reset(reset),
    .ld(ld),
    .ld_value(ld_val),
    .dec(dec),
    .count(count),
    .term(term)
  );
  // next state and done pulse; load overrides everything and drops any terminal tick
  always_comb begin
    state_nxt = state;
    done_nxt = 1'b0;
    case (state)
      ST_IDLE: state_nxt = !start ? ST_IDLE : (count != '0) ? ST_RUN : ST_DONE;
      ST_RUN:  state_nxt = pause ? ST_HOLD : (term && !rl) ? ST_DONE : ST_RUN;
      ST_HOLD: state_nxt = start ? ST_RUN : ST_HOLD;
      default: state_nxt = ST_IDLE;
    endcase
    done_nxt = !load && (term || (state == ST_IDLE && start && count == '0));
    if (load) state_nxt = ST_IDLE;
  end
  // state and registered done pulse
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= ST_IDLE;
      done <= 1'b0;
    end else begin
      state <= state_nxt;
      done <= done_nxt;
    end
  assign busy = (state == ST_RUN) || (state == ST_HOLD);
  assign zero = (count == '0);
endmodule

// File: tb/tb_countdown_timer_16.sv
// tb_countdown_timer_16: directed self-checking bench for countdown_timer_16
module tb_countdown_timer_16;
  logic clock = 1'b0, reset = 1'b1, load = 1'b0, start = 1'b0, pause = 1'b0, enable = 1'b0;
  logic [15:0] load_value = '0, count;
  logic busy, done, zero;
  int checks = 0, failures = 0;
  countdown_timer_16 dut (
    .clock(clock), .reset(reset), .load(load), .load_value(load_value),
    .start(start), .pause(pause), .enable(enable),
    .count(count), .busy(busy), .done(done), .zero(zero)
  );
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clock);
    #1;
  endtask
  task automatic do_load(input logic [15:0] v);
    load = 1'b1;
    load_value = v;
    step();
    load = 1'b0;
  endtask
  initial begin
    #1;
    chk("rst_count", 32'(count), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_zero", 32'(zero), 1);
    step();
    reset = 1'b0;
    // load 5, run to terminal count
    do_load(16'd5);
    chk("t2_load", 32'(count), 5);
    chk("t2_idle_busy", 32'(busy), 0);
    start = 1'b1;
    enable = 1'b1;
    step();
    start = 1'b0;
    chk("t2_start_cnt", 32'(count), 5);
    chk("t2_start_busy", 32'(busy), 1);
    for (int i = 4; i >= 1; i--) begin
      step();
      chk("t2_cnt", 32'(count), 32'(i));
      chk("t2_nodone", 32'(done), 0);
    end
    step();
    chk("t2_term_cnt", 32'(count), 0);
    chk("t2_term_done", 32'(done), 1);
    chk("t2_term_busy", 32'(busy), 0);
    step();
    chk("t2_after_done", 32'(done), 0);
    chk("t2_after_busy", 32'(busy), 0);
    chk("t2_after_cnt", 32'(count), 0);
    // pause / resume
    do_load(16'd10);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chk("t3_before_pause", 32'(count), 7);
    pause = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t3_hold_cnt", 32'(count), 7);
      chk("t3_hold_busy", 32'(busy), 1);
    end
    pause = 1'b0;
    step();
    chk("t3_hold_nopause", 32'(count), 7);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("t3_resume_cnt", 32'(count), 7);
    for (int i = 6; i >= 1; i--) begin
      step();
      chk("t3_cnt", 32'(count), 32'(i));
    end
    step();
    chk("t3_term_cnt", 32'(count), 0);
    chk("t3_term_done", 32'(done), 1);
    // start from zero
    do_load(16'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("t4_done", 32'(done), 1);
    chk("t4_cnt", 32'(count), 0);
    chk("t4_busy", 32'(busy), 0);
    step();
    chk("t4_done_clr", 32'(done), 0);
    chk("t4_nowrap", 32'(count), 0);
    chk("t4_zero", 32'(zero), 1);
    // load coincident with terminal tick
    do_load(16'd2);
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    chk("t5_cnt1", 32'(count), 1);
    load = 1'b1;
    load_value = 16'd1;
    step();
    load = 1'b0;
    chk("t5_cnt", 32'(count), 1);
    chk("t5_done", 32'(done), 0);
    chk("t5_busy", 32'(busy), 0);
    step();
    chk("t5_done2", 32'(done), 0);
    chk("t5_idle_cnt", 32'(count), 1);
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    do_load(16'd3);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int r = 0; r < 2; r++) begin
      step();
      chk("t6_cnt2", 32'(count), 2);
      step();
      chk("t6_cnt1", 32'(count), 1);
      step();
      chk("t6_reload", 32'(count), 3);
      chk("t6_done", 32'(done), 1);
      chk("t6_busy", 32'(busy), 1);
    end
    step();
    chk("t6_done_clr", 32'(done), 0);
`endif
    // async reset mid-run
    do_load(16'd37);
    enable = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("t1_run_busy", 32'(busy), 1);
    chk("t1_run_cnt", 32'(count), 37);
    #2 reset = 1'b1;
    #1;
    chk("t1_cnt", 32'(count), 0);
    chk("t1_busy", 32'(busy), 0);
    chk("t1_done", 32'(done), 0);
    chk("t1_zero", 32'(zero), 1);
    step();
    reset = 1'b0;
    step();
    chk("t1_after", 32'(busy), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
